// File: rtl/multicycle_ctrl32.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl32
//
// Multi-cycle control FSM for the KLP32 RV32I datapath. It sequences each
// instruction through FETCH / DECODE / EXECUTE / (MEM) / WB. It decodes the
// instruction register contents into datapath selects and write strobes.
// Data memory accesses are stretched by a ready handshake. An unsupported
// instruction halts the machine until reset.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous reset, active high
//   instr_i      instruction register contents (valid from DECODE onward)
//   br_eq_i      rs1 == rs2
//   br_lt_i      rs1 <  rs2 (signed)
//   br_ltu_i     rs1 <  rs2 (unsigned)
//   mem_ready_i  data memory completes its access this cycle
//   ir_write_o   latch instruction memory output into the IR
//   pc_write_o   load PC from the pc-select mux
//   pc_sel_o     0 = pc+4, 1 = ALU result
//   reg_write_o  register file write enable
//   imm_sel_o    0 I, 1 S, 2 B, 3 U, 4 J
//   a_sel_o      0 = rs1 data, 1 = PC
//   b_sel_o      0 = rs2 data, 1 = immediate
//   alu_sel_o    0 ADD .. 9 AND, 10 PASS_B
//   dmem_re_o    data memory read request
//   dmem_we_o    data memory write request
//   wb_sel_o     0 ALU, 1 memory, 2 pc+4
//   illegal_o    sticky illegal-instruction flag
//   state_o      FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5
// ---------------------------------------------------------------------------
module multicycle_ctrl32 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_i,
    input  logic        br_eq_i,
    input  logic        br_lt_i,
    input  logic        br_ltu_i,
    input  logic        mem_ready_i,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_sel_o,
    output logic        reg_write_o,
    output logic [2:0]  imm_sel_o,
    output logic        a_sel_o,
    output logic        b_sel_o,
    output logic [3:0]  alu_sel_o,
    output logic        dmem_re_o,
    output logic        dmem_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StHalt    = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;
    localparam logic [3:0] AluPass = 4'd10;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rd;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7_b5 = instr_i[30];
    assign rd        = instr_i[11:7];

    logic is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;

    assign is_r      = (opcode == OpR);
    assign is_ialu   = (opcode == OpIAlu);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_lui    = (opcode == OpLui);
    assign is_auipc  = (opcode == OpAuipc);

    logic legal;
    assign legal = (is_r | is_ialu | is_load | is_store | is_jal | is_jalr | is_lui | is_auipc)
                 | (is_branch & (funct3 != 3'b010) & (funct3 != 3'b011));

    // Branch resolution; funct3[0] inverts the base comparison.
    logic br_base, br_taken;
    always_comb begin
        br_base = 1'b0;
        unique case (funct3[2:1])
            2'b00:   br_base = br_eq_i;
            2'b10:   br_base = br_lt_i;
            2'b11:   br_base = br_ltu_i;
            default: br_base = 1'b0;
        endcase
        br_taken = br_base ^ funct3[0];
    end

    // ALU operation from {funct7[5], funct3}; for I-ALU the funct7 bit only
    // distinguishes SRLI/SRAI, since elsewhere bit 30 belongs to the immediate.
    logic       alt_bit;
    logic [3:0] alu_arith;
    always_comb begin
        alt_bit   = is_r ? funct7_b5 : (funct7_b5 & (funct3 == 3'b101));
        alu_arith = AluAdd;
        unique case (funct3)
            3'b000:  alu_arith = alt_bit ? AluSub : AluAdd;
            3'b001:  alu_arith = AluSll;
            3'b010:  alu_arith = AluSlt;
            3'b011:  alu_arith = AluSltu;
            3'b100:  alu_arith = AluXor;
            3'b101:  alu_arith = alt_bit ? AluSra : AluSrl;
            3'b110:  alu_arith = AluOr;
            3'b111:  alu_arith = AluAnd;
            default: alu_arith = AluAdd;
        endcase
    end

    // Datapath selects: a pure function of the instruction word.
    logic [2:0] imm_sel;
    logic       a_sel, b_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    always_comb begin
        imm_sel = ImmI;
        a_sel   = 1'b0;
        b_sel   = 1'b1;
        alu_sel = AluAdd;
        wb_sel  = WbAlu;
        if (is_r) begin
            b_sel   = 1'b0;
            alu_sel = alu_arith;
        end else if (is_ialu) begin
            alu_sel = alu_arith;
        end else if (is_lui) begin
            imm_sel = ImmU;
            alu_sel = AluPass;
        end else if (is_auipc) begin
            imm_sel = ImmU;
            a_sel   = 1'b1;
        end else if (is_jal) begin
            imm_sel = ImmJ;
            a_sel   = 1'b1;
            wb_sel  = WbPc4;
        end else if (is_branch) begin
            imm_sel = ImmB;
            a_sel   = 1'b1;
        end else if (is_store) begin
            imm_sel = ImmS;
        end else if (is_load) begin
            wb_sel  = WbMem;
        end else if (is_jalr) begin
            wb_sel  = WbPc4;
        end
    end

    // Next state and strobes
    logic ir_write, pc_write, pc_sel, reg_write, dmem_re, dmem_we;
    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        reg_write = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                state_d = legal ? StExecute : StHalt;
            end
            StExecute: begin
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = br_taken;
                    state_d  = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_re = is_load;
                dmem_we = is_store;
                if (mem_ready_i) begin
                    if (is_load) begin
                        state_d = StWb;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                end
            end
            StWb: begin
                reg_write = (rd != 5'd0);
                pc_write  = 1'b1;
                pc_sel    = is_jal | is_jalr;
                state_d   = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign illegal_d = illegal_q | (state_d == StHalt);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset is asynchronous on the outputs too: the state register already
    // sits in FETCH, whose ir_write strobe must not show while reset is held.
    always_comb begin
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_sel_o    = 1'b0;
        reg_write_o = 1'b0;
        imm_sel_o   = ImmI;
        a_sel_o     = 1'b0;
        b_sel_o     = 1'b0;
        alu_sel_o   = AluAdd;
        dmem_re_o   = 1'b0;
        dmem_we_o   = 1'b0;
        wb_sel_o    = WbAlu;
        if (!reset_i) begin
            ir_write_o  = ir_write;
            pc_write_o  = pc_write;
            pc_sel_o    = pc_sel;
            reg_write_o = reg_write;
            imm_sel_o   = imm_sel;
            a_sel_o     = a_sel;
            b_sel_o     = b_sel;
            alu_sel_o   = alu_sel;
            dmem_re_o   = dmem_re;
            dmem_we_o   = dmem_we;
            wb_sel_o    = wb_sel;
        end
    end

    assign illegal_o = illegal_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl32.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl32
//
// Directed testbench for multicycle_ctrl32. Outputs are sampled 1 time unit
// after each rising edge; expected values are hand-computed per instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl32;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] instr_i;
    logic        br_eq_i, br_lt_i, br_ltu_i, mem_ready_i;
    logic        ir_write_o, pc_write_o, pc_sel_o, reg_write_o;
    logic [2:0]  imm_sel_o;
    logic        a_sel_o, b_sel_o;
    logic [3:0]  alu_sel_o;
    logic        dmem_re_o, dmem_we_o;
    logic [1:0]  wb_sel_o;
    logic        illegal_o;
    logic [2:0]  state_o;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_ctrl32 dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .instr_i     (instr_i),
        .br_eq_i     (br_eq_i),
        .br_lt_i     (br_lt_i),
        .br_ltu_i    (br_ltu_i),
        .mem_ready_i (mem_ready_i),
        .ir_write_o  (ir_write_o),
        .pc_write_o  (pc_write_o),
        .pc_sel_o    (pc_sel_o),
        .reg_write_o (reg_write_o),
        .imm_sel_o   (imm_sel_o),
        .a_sel_o     (a_sel_o),
        .b_sel_o     (b_sel_o),
        .alu_sel_o   (alu_sel_o),
        .dmem_re_o   (dmem_re_o),
        .dmem_we_o   (dmem_we_o),
        .wb_sel_o    (wb_sel_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [2:0] SFetch = 3'd0, SDecode = 3'd1, SExec = 3'd2;
    localparam logic [2:0] SMem = 3'd3, SWb = 3'd4, SHalt = 3'd5;

    // Strobe bundle {ir_write, pc_write, reg_write, dmem_re, dmem_we}
    function automatic logic [4:0] strobes();
        return {ir_write_o, pc_write_o, reg_write_o, dmem_re_o, dmem_we_o};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        instr_i     = 32'h002081B3;
        br_eq_i     = 1'b0;
        br_lt_i     = 1'b0;
        br_ltu_i    = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        // Reset state
        check_eq("rst_state", state_o, SFetch);
        check_eq("rst_strobes", strobes(), 5'b0);
        check_eq("rst_illegal", illegal_o, 1'b0);
        check_eq("rst_selects", {imm_sel_o, a_sel_o, b_sel_o, alu_sel_o, wb_sel_o, pc_sel_o}, 0);
        step();
        step();
        reset_i = 1'b0;
        #1;

        // ADD x3,x1,x2
        check_eq("add_fetch_state", state_o, SFetch);
        check_eq("add_fetch_strobes", strobes(), 5'b10000);
        step();
        check_eq("add_decode_state", state_o, SDecode);
        check_eq("add_decode_strobes", strobes(), 5'b0);
        step();
        check_eq("add_exec_state", state_o, SExec);
        check_eq("add_exec_strobes", strobes(), 5'b0);
        step();
        check_eq("add_wb_state", state_o, SWb);
        check_eq("add_wb_sel", {alu_sel_o, a_sel_o, b_sel_o, wb_sel_o}, {4'd0, 1'b0, 1'b0, 2'd0});
        check_eq("add_wb_strobes", strobes(), 5'b01100);
        check_eq("add_wb_pcsel", pc_sel_o, 1'b0);
        step();
        check_eq("add_done_state", state_o, SFetch);

        // LW x5,8(x1) with two wait cycles
        instr_i = 32'h0080A283;
        step();
        step();
        check_eq("lw_exec_state", state_o, SExec);
        step();
        check_eq("lw_mem1", {state_o, dmem_re_o, dmem_we_o}, {SMem, 2'b10});
        step();
        check_eq("lw_mem2", {state_o, dmem_re_o, dmem_we_o}, {SMem, 2'b10});
        step();
        check_eq("lw_mem3", {state_o, dmem_re_o, dmem_we_o}, {SMem, 2'b10});
        check_eq("lw_mem3_nopc", pc_write_o, 1'b0);
        mem_ready_i = 1'b1;
        #1;
        check_eq("lw_mem3_rdy_re", dmem_re_o, 1'b1);
        step();
        mem_ready_i = 1'b0;
        check_eq("lw_wb_state", state_o, SWb);
        check_eq("lw_wb_sel", {wb_sel_o, imm_sel_o, b_sel_o}, {2'd1, 3'd0, 1'b1});
        check_eq("lw_wb_strobes", strobes(), 5'b01100);
        step();
        check_eq("lw_done_state", state_o, SFetch);

        // SW x2,4(x1) zero wait: FETCH DECODE EXEC MEM(ready) -> FETCH
        instr_i = 32'h0020A223;
        step();
        step();
        step();
        mem_ready_i = 1'b1;
        #1;
        check_eq("sw_mem", {state_o, strobes(), imm_sel_o}, {SMem, 5'b01001, 3'd1});
        check_eq("sw_mem_pcsel", pc_sel_o, 1'b0);
        step();
        mem_ready_i = 1'b0;
        check_eq("sw_done_state", state_o, SFetch);

        // BEQ x1,x2,+8 taken
        instr_i = 32'h00208463;
        br_eq_i = 1'b1;
        step();
        step();
        check_eq("beq_t_exec", {state_o, pc_write_o, pc_sel_o}, {SExec, 2'b11});
        check_eq("beq_t_sel", {imm_sel_o, a_sel_o, b_sel_o, alu_sel_o}, {3'd2, 2'b11, 4'd0});
        step();
        check_eq("beq_t_done", state_o, SFetch);
        // Not taken
        br_eq_i = 1'b0;
        step();
        step();
        check_eq("beq_nt_exec", {state_o, pc_write_o, pc_sel_o}, {SExec, 2'b10});
        step();
        // BGEU (funct3 111) with ltu=1 -> not taken
        instr_i  = 32'h0020F463;
        br_ltu_i = 1'b1;
        step();
        step();
        check_eq("bgeu_exec_pcsel", pc_sel_o, 1'b0);
        br_ltu_i = 1'b0;
        #1;
        check_eq("bgeu_exec_pcsel2", pc_sel_o, 1'b1);
        step();

        // JAL x1,+8
        instr_i = 32'h008000EF;
        step();
        step();
        step();
        check_eq("jal_wb", {state_o, reg_write_o, wb_sel_o, pc_sel_o, imm_sel_o},
                 {SWb, 1'b1, 2'd2, 1'b1, 3'd4});
        step();

        // ADD x0: no register write
        instr_i = 32'h00208033;
        step();
        step();
        step();
        check_eq("add_x0_wb", {state_o, reg_write_o, pc_write_o}, {SWb, 2'b01});
        step();

        // Decode of selects (pure function of instr)
        instr_i = 32'h402081B3; #1;
        check_eq("sub_alu", alu_sel_o, 4'd1);
        instr_i = 32'h4020D193; #1;
        check_eq("srai_alu", {alu_sel_o, b_sel_o}, {4'd7, 1'b1});
        instr_i = 32'hC0008193; #1;
        check_eq("addi_neg_alu", alu_sel_o, 4'd0);
        instr_i = 32'h123450B7; #1;
        check_eq("lui_sel", {alu_sel_o, imm_sel_o, a_sel_o, b_sel_o}, {4'd10, 3'd3, 2'b01});
        instr_i = 32'h00001097; #1;
        check_eq("auipc_sel", {alu_sel_o, imm_sel_o, a_sel_o, b_sel_o}, {4'd0, 3'd3, 2'b11});

        // Illegal instruction -> HALT
        instr_i = 32'h00000000;
        step();
        step();
        check_eq("ill_state", state_o, SHalt);
        check_eq("ill_flag", illegal_o, 1'b1);
        mem_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("halt_hold_%0d", i), {state_o, strobes(), illegal_o},
                     {SHalt, 5'b0, 1'b1});
        end
        mem_ready_i = 1'b0;
        reset_i = 1'b1;
        #1;
        check_eq("ill_rst", {state_o, illegal_o, strobes()}, {SFetch, 1'b0, 5'b0});
        step();
        reset_i = 1'b0;
        #1;
        check_eq("ill_rel", {state_o, ir_write_o}, {SFetch, 1'b1});

        // Reserved branch funct3 010 halts
        instr_i = 32'h0020A463;
        step();
        step();
        check_eq("bres_halt", {state_o, illegal_o}, {SHalt, 1'b1});
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        #1;

        // Reset mid-EXECUTE of ADD
        instr_i = 32'h002081B3;
        step();
        step();
        check_eq("mid_exec_state", state_o, SExec);
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("mid_rst_strobes", strobes(), 5'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("mid_rst_hold_%0d", i), {strobes(), state_o}, {5'b0, SFetch});
        end
        reset_i = 1'b0;
        #1;
        check_eq("mid_rst_rel", {state_o, ir_write_o, reg_write_o}, {SFetch, 2'b10});
        step();
        check_eq("mid_rst_decode", state_o, SDecode);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
